// File: rtl/btn_arb_pkg.sv
// Shared types and the round-robin selection helper for the button arbiter.
package btn_arb_pkg;

  typedef enum logic [0:0] {IDLE = 1'b0, OFFER = 1'b1} arb_state_t;

  localparam int N_REQ_DEF = 4;
  localparam int N_REQ_MAX = 16;

  // First set bit of pend searching ptr, ptr+1, ... and wrapping past n-1 to 0.
  function automatic int rr_pick(input logic [N_REQ_MAX-1:0] pend, input int ptr, input int n);
    int   idx;
    int   pick;
    logic found;
    pick  = ptr;
    found = 1'b0;
    for (int k = 0; k < N_REQ_MAX; k++) begin
      idx = ptr + k;
      if (idx >= n) idx = idx - n;
      if ((k < n) && !found && pend[idx[3:0]]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/rise_detect.sv
// One-cycle rising-edge pulse from a synchronised level. The history register
// resets high so a button held through reset release is not seen as a press.
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic lvl,
  output logic rise
);

  logic prev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) prev <= 1'b1;
    else        prev <= lvl;
  end

  assign rise = lvl & ~prev;

endmodule

// File: rtl/btn_rr_arbiter.sv
// Turns button presses into pending requests and grants them one at a time,
// round-robin, to a shared consumer over a valid/ready handshake.
module btn_rr_arbiter
  import btn_arb_pkg::*;
#(
  parameter int N_REQ  = N_REQ_DEF,
  parameter int IDX_W  = $clog2(N_REQ),
  parameter int DROP_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_REQ-1:0]  btn_lvl,
  input  logic              cmd_ready,
  output logic              cmd_valid,
  output logic [IDX_W-1:0]  cmd_idx,
  output logic [N_REQ-1:0]  grant_onehot,
  output logic [N_REQ-1:0]  pending,
  output logic [DROP_W-1:0] drop_cnt,
  output logic              busy
);

  arb_state_t             state;
  logic [IDX_W-1:0]       ptr;
  logic [IDX_W-1:0]       pick_idx;
  logic [N_REQ_MAX-1:0]   pend_ext;
  logic [N_REQ-1:0]       rise;
  logic [N_REQ-1:0]       clr;
  logic [N_REQ-1:0]       drop;
  logic                   accept;

  // Adds the number of dropped channels, clamping at all-ones instead of wrapping.
  function automatic logic [DROP_W-1:0] sat_add(input logic [DROP_W-1:0] acc,
                                                input logic [N_REQ-1:0]  hits);
    logic [DROP_W+4:0] sum;
    sum = {5'd0, acc};
    for (int i = 0; i < N_REQ; i++) sum = sum + (DROP_W+5)'(hits[i]);
    if (sum > {5'd0, {DROP_W{1'b1}}}) return {DROP_W{1'b1}};
    return sum[DROP_W-1:0];
  endfunction

  for (genvar g = 0; g < N_REQ; g++) begin : g_rise
    rise_detect u_rise (
      .clk   (clk),
      .reset (reset),
      .lvl   (btn_lvl[g]),
      .rise  (rise[g])
    );
  end

  always_comb begin
    pend_ext             = '0;
    pend_ext[N_REQ-1:0]  = pending;
    pick_idx             = IDX_W'(rr_pick(pend_ext, int'(ptr), N_REQ));
  end

  // A press landing on the channel being accepted survives; otherwise a press
  // on an already-pending channel is lost and counted.
  assign accept = (state == OFFER) && cmd_ready;
  assign clr    = accept ? (N_REQ'(1) << cmd_idx) : '0;
  assign drop   = rise & pending & ~clr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      pending  <= '0;
      ptr      <= '0;
      cmd_idx  <= '0;
      drop_cnt <= '0;
    end else begin
      pending  <= (pending & ~clr) | rise;
      drop_cnt <= sat_add(drop_cnt, drop);
      case (state)
        IDLE: begin
          if (|pending) begin
            cmd_idx <= pick_idx;
            state   <= OFFER;
          end
        end
        OFFER: begin
          if (cmd_ready) begin
            ptr   <= (cmd_idx == IDX_W'(N_REQ-1)) ? '0 : cmd_idx + IDX_W'(1);
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign cmd_valid    = (state == OFFER);
  assign grant_onehot = cmd_valid ? (N_REQ'(1) << cmd_idx) : '0;
  assign busy         = (state != IDLE) || (|pending);

endmodule

// File: tb/tb_btn_rr_arbiter.sv
// Bench for btn_rr_arbiter: directed scenarios plus randomized traffic
// compared against a behavioural model.
module tb_btn_rr_arbiter;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [N-1:0] btn_lvl = '0;
  logic         cmd_ready = 1'b0;
  logic         cmd_valid;
  logic [1:0]   cmd_idx;
  logic [N-1:0] grant_onehot;
  logic [N-1:0] pending;
  logic [7:0]   drop_cnt;
  logic         busy;

  logic [N-1:0] btn_lvl2 = '0;
  logic         cmd_ready2 = 1'b0;
  logic         cmd_valid2;
  logic [1:0]   cmd_idx2;
  logic [N-1:0] grant2;
  logic [N-1:0] pending2;
  logic [1:0]   drop2;
  logic         busy2;

  int n_checks = 0;
  int n_fail   = 0;

  btn_rr_arbiter #(.N_REQ(N), .DROP_W(8)) dut (
    .clk(clk), .reset(reset), .btn_lvl(btn_lvl), .cmd_ready(cmd_ready),
    .cmd_valid(cmd_valid), .cmd_idx(cmd_idx), .grant_onehot(grant_onehot),
    .pending(pending), .drop_cnt(drop_cnt), .busy(busy)
  );

  btn_rr_arbiter #(.N_REQ(N), .DROP_W(2)) dut_sat (
    .clk(clk), .reset(reset), .btn_lvl(btn_lvl2), .cmd_ready(cmd_ready2),
    .cmd_valid(cmd_valid2), .cmd_idx(cmd_idx2), .grant_onehot(grant2),
    .pending(pending2), .drop_cnt(drop2), .busy(busy2)
  );

  always #5 clk = ~clk;

  // Behavioural model of the main instance
  int           m_offer = 0;
  int           m_idx   = 0;
  int           m_ptr   = 0;
  int           m_drop  = 0;
  logic [N-1:0] m_pend  = '0;
  logic [N-1:0] m_prev  = '1;

  always @(posedge clk or negedge reset) begin : model
    logic [N-1:0] r;
    logic [N-1:0] np;
    int           drops;
    int           pos;
    logic         found;
    logic         taken;
    if (!reset) begin
      m_offer <= 0;
      m_idx   <= 0;
      m_ptr   <= 0;
      m_drop  <= 0;
      m_pend  <= '0;
      m_prev  <= '1;
    end else begin
      r     = btn_lvl & ~m_prev;
      np    = '0;
      drops = 0;
      for (int i = 0; i < N; i++) begin
        taken = (m_offer == 1) && cmd_ready && (m_idx == i);
        if (r[i] && !taken && m_pend[i]) drops++;
        np[i] = r[i] | (m_pend[i] & !taken);
      end
      if (m_offer == 0 && m_pend != 0) begin
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
          pos = (m_ptr + k) % N;
          if (!found && m_pend[pos]) begin
            m_idx <= pos;
            found = 1'b1;
          end
        end
        m_offer <= 1;
      end else if (m_offer == 1 && cmd_ready) begin
        m_ptr   <= (m_idx + 1) % N;
        m_offer <= 0;
      end
      m_drop <= (m_drop + drops > 255) ? 255 : m_drop + drops;
      m_pend <= np;
      m_prev <= btn_lvl;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(1);
  endtask

  task automatic test_reset();
    tick(2);
    n_checks++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", cmd_valid); end
    n_checks++; if (grant_onehot !== 4'b0000) begin n_fail++; $display("FAIL reset_grant: got %b want 0000", grant_onehot); end
    n_checks++; if (pending !== 4'b0000) begin n_fail++; $display("FAIL reset_pending: got %b want 0000", pending); end
    n_checks++; if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_drop: got %0d want 0", drop_cnt); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b want 0", busy); end
    n_checks++; if (cmd_idx !== 2'd0) begin n_fail++; $display("FAIL reset_idx: got %0d want 0", cmd_idx); end
    reset = 1'b1;
    tick(1);
  endtask

  task automatic test_single_press();
    btn_lvl = 4'b0100;
    cmd_ready = 1'b1;
    tick(1);
    n_checks++; if (pending !== 4'b0100) begin n_fail++; $display("FAIL single_pending_set: got %b want 0100", pending); end
    n_checks++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL single_valid_early: got %0b want 0", cmd_valid); end
    tick(1);
    n_checks++; if (cmd_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %0b want 1", cmd_valid); end
    n_checks++; if (cmd_idx !== 2'd2) begin n_fail++; $display("FAIL single_idx: got %0d want 2", cmd_idx); end
    n_checks++; if (grant_onehot !== 4'b0100) begin n_fail++; $display("FAIL single_grant: got %b want 0100", grant_onehot); end
    tick(1);
    n_checks++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL single_valid_after: got %0b want 0", cmd_valid); end
    n_checks++; if (pending !== 4'b0000) begin n_fail++; $display("FAIL single_pending_clr: got %b want 0000", pending); end
    btn_lvl = 4'b0000;
    tick(1);
  endtask

  // Pointer is left at 3 by the single press, so 3 must win before 0.
  task automatic test_wrap();
    btn_lvl = 4'b1001;
    cmd_ready = 1'b1;
    tick(1);
    n_checks++; if (pending !== 4'b1001) begin n_fail++; $display("FAIL wrap_pending: got %b want 1001", pending); end
    tick(1);
    n_checks++; if (cmd_valid !== 1'b1 || cmd_idx !== 2'd3) begin n_fail++; $display("FAIL wrap_first: got v=%0b idx=%0d want v=1 idx=3", cmd_valid, cmd_idx); end
    tick(1);
    n_checks++; if (cmd_valid !== 1'b0 || pending !== 4'b0001) begin n_fail++; $display("FAIL wrap_gap: got v=%0b pend=%b want v=0 pend=0001", cmd_valid, pending); end
    tick(1);
    n_checks++; if (cmd_valid !== 1'b1 || cmd_idx !== 2'd0) begin n_fail++; $display("FAIL wrap_second: got v=%0b idx=%0d want v=1 idx=0", cmd_valid, cmd_idx); end
    tick(1);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wrap_busy: got %0b want 0", busy); end
    btn_lvl = 4'b0000;
    tick(1);
  endtask

  task automatic test_simultaneous();
    logic exp_v [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    int   exp_i [7] = '{0, 0, 0, 1, 0, 3, 0};
    pulse_reset();
    btn_lvl = 4'b1011;
    cmd_ready = 1'b1;
    for (int s = 0; s < 7; s++) begin
      tick(1);
      n_checks++;
      if (cmd_valid !== exp_v[s] || (exp_v[s] && cmd_idx !== 2'(exp_i[s]))) begin
        n_fail++;
        $display("FAIL simul_step%0d: got v=%0b idx=%0d want v=%0b idx=%0d", s, cmd_valid, cmd_idx, exp_v[s], exp_i[s]);
      end
    end
    n_checks++; if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL simul_drop: got %0d want 0", drop_cnt); end
    btn_lvl = 4'b0000;
    tick(1);
  endtask

  task automatic test_backpressure();
    cmd_ready = 1'b0;
    btn_lvl = 4'b0010;
    tick(2);
    for (int c = 0; c < 20; c++) begin
      btn_lvl[1] = (c < 4) || (c >= 8 && c < 12) || (c >= 16);
      tick(1);
      n_checks++;
      if (cmd_valid !== 1'b1 || cmd_idx !== 2'd1) begin
        n_fail++;
        $display("FAIL bp_hold_c%0d: got v=%0b idx=%0d want v=1 idx=1", c, cmd_valid, cmd_idx);
      end
    end
    n_checks++; if (drop_cnt !== 8'd2) begin n_fail++; $display("FAIL bp_drop: got %0d want 2", drop_cnt); end
    cmd_ready = 1'b1;
    tick(1);
    n_checks++; if (cmd_valid !== 1'b0 || pending !== 4'b0000) begin n_fail++; $display("FAIL bp_release: got v=%0b pend=%b want v=0 pend=0000", cmd_valid, pending); end
    btn_lvl = 4'b0000;
    tick(2);
  endtask

  task automatic test_collision();
    cmd_ready = 1'b0;
    btn_lvl = 4'b0001;
    tick(2);
    n_checks++; if (cmd_valid !== 1'b1 || cmd_idx !== 2'd0) begin n_fail++; $display("FAIL coll_offer: got v=%0b idx=%0d want v=1 idx=0", cmd_valid, cmd_idx); end
    btn_lvl = 4'b0000;
    tick(1);
    btn_lvl = 4'b0001;
    cmd_ready = 1'b1;
    tick(1);
    n_checks++; if (pending !== 4'b0001 || cmd_valid !== 1'b0) begin n_fail++; $display("FAIL coll_keep: got pend=%b v=%0b want pend=0001 v=0", pending, cmd_valid); end
    n_checks++; if (drop_cnt !== 8'd2) begin n_fail++; $display("FAIL coll_drop: got %0d want 2", drop_cnt); end
    tick(1);
    n_checks++; if (cmd_valid !== 1'b1 || cmd_idx !== 2'd0) begin n_fail++; $display("FAIL coll_regrant: got v=%0b idx=%0d want v=1 idx=0", cmd_valid, cmd_idx); end
    tick(1);
    n_checks++; if (pending !== 4'b0000) begin n_fail++; $display("FAIL coll_clear: got %b want 0000", pending); end
    btn_lvl = 4'b0000;
    cmd_ready = 1'b0;
    tick(1);
  endtask

  task automatic test_saturation();
    btn_lvl2 = 4'b0001;
    tick(2);
    n_checks++; if (cmd_valid2 !== 1'b1) begin n_fail++; $display("FAIL sat_offer: got %0b want 1", cmd_valid2); end
    for (int p = 0; p < 5; p++) begin
      btn_lvl2 = 4'b0000;
      tick(1);
      btn_lvl2 = 4'b0001;
      tick(1);
      if (p == 1) begin
        n_checks++; if (drop2 !== 2'd2) begin n_fail++; $display("FAIL sat_mid: got %0d want 2", drop2); end
      end
    end
    n_checks++; if (drop2 !== 2'd3) begin n_fail++; $display("FAIL sat_final: got %0d want 3", drop2); end
    n_checks++; if (pending2 !== 4'b0001) begin n_fail++; $display("FAIL sat_pending: got %b want 0001", pending2); end
    btn_lvl2 = 4'b0000;
  endtask

  task automatic test_reset_mid_offer();
    cmd_ready = 1'b0;
    btn_lvl = 4'b0010;
    tick(2);
    n_checks++; if (cmd_valid !== 1'b1) begin n_fail++; $display("FAIL rst_pre_offer: got %0b want 1", cmd_valid); end
    #2;
    reset = 1'b0;
    #1;
    n_checks++; if (cmd_valid !== 1'b0 || grant_onehot !== 4'b0000) begin n_fail++; $display("FAIL rst_async: got v=%0b g=%b want v=0 g=0000", cmd_valid, grant_onehot); end
    n_checks++; if (busy !== 1'b0 || pending !== 4'b0000) begin n_fail++; $display("FAIL rst_async_state: got busy=%0b pend=%b want 0 0000", busy, pending); end
    tick(2);
    reset = 1'b1;
    tick(3);
    n_checks++; if (pending !== 4'b0000 || cmd_valid !== 1'b0) begin n_fail++; $display("FAIL rst_held_btn: got pend=%b v=%0b want 0000 0", pending, cmd_valid); end
    btn_lvl = 4'b0000;
    tick(1);
    btn_lvl = 4'b0010;
    tick(1);
    n_checks++; if (pending !== 4'b0010) begin n_fail++; $display("FAIL rst_repress: got %b want 0010", pending); end
    tick(1);
    n_checks++; if (cmd_valid !== 1'b1 || cmd_idx !== 2'd1) begin n_fail++; $display("FAIL rst_regrant: got v=%0b idx=%0d want v=1 idx=1", cmd_valid, cmd_idx); end
    cmd_ready = 1'b1;
    btn_lvl = 4'b0000;
    tick(2);
  endtask

  task automatic test_random();
    logic [N-1:0] exp_g;
    for (int c = 0; c < 500; c++) begin
      if ($urandom_range(0, 2) == 0) btn_lvl[$urandom_range(0, N-1)] ^= 1'b1;
      cmd_ready = ($urandom_range(0, 3) != 0);
      tick(1);
      exp_g = (m_offer == 1) ? (4'b0001 << m_idx) : 4'b0000;
      n_checks++;
      if (cmd_valid !== (m_offer == 1) || grant_onehot !== exp_g || ((m_offer == 1) && cmd_idx !== 2'(m_idx))) begin
        n_fail++;
        $display("FAIL rand_grant_c%0d: got v=%0b idx=%0d g=%b want v=%0d idx=%0d g=%b", c, cmd_valid, cmd_idx, grant_onehot, m_offer, m_idx, exp_g);
      end
      n_checks++;
      if (pending !== m_pend || drop_cnt !== 8'(m_drop) || busy !== ((m_offer == 1) || (m_pend != 0))) begin
        n_fail++;
        $display("FAIL rand_state_c%0d: got pend=%b drop=%0d busy=%0b want pend=%b drop=%0d", c, pending, drop_cnt, busy, m_pend, m_drop);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_wrap();
    test_simultaneous();
    test_backpressure();
    test_collision();
    test_saturation();
    test_reset_mid_offer();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
